// File: rtl/seq_detector_param_pkg.sv
// Purpose : shared defaults and width helper for the parameterised serial sequence detector.
// Latency : n/a (package only).
// Backpress: n/a (package only).
//
// Contents: DEF_PATTERN / DEF_LEN / DEF_OVERLAP reset-time configuration,
//           lw_of() giving the width needed to hold a fill level 0..MAX_LEN.
package seq_det_pkg;

   // Configuration loaded while reset is asserted: overlapping detector for 1011.
   localparam logic [31:0] DEF_PATTERN = 32'b1011;
   localparam int          DEF_LEN     = 4;
   localparam bit          DEF_OVERLAP = 1'b1;

   // Width of a counter that must represent every value 0..max_len inclusive.
   function automatic int lw_of(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Purpose : bundles the detector's serial input, configuration and status signals.
// Latency : n/a (wiring only).
// Backpress: none; tick is a strobe and the detector always accepts it.
//
// Signals: in/tick    serial bit and its sample strobe
//          load, cfg_*  configuration latch request and values
//          clr_count  synchronous clear of the match counter
//          out, progress, match_count  detector status
// master drives the stimulus side, slave is the detector side.
interface seq_detector_param_if import seq_det_pkg::*; #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
);
   localparam int LW = lw_of(MAX_LEN);

   logic               in;
   logic               tick;
   logic               load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LW-1:0]      cfg_len;
   logic               cfg_overlap;
   logic               clr_count;
   logic               out;
   logic [LW-1:0]      progress;
   logic [CNT_W-1:0]   match_count;

   modport master (
      output in, tick, load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
      input  out, progress, match_count
   );

   modport slave (
      input  in, tick, load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
      output out, progress, match_count
   );

endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Purpose : up-counter that sticks at MAX_VAL instead of wrapping; clear wins over increment.
// Latency : count reflects inc/clr one clock after they are sampled.
// Backpress: none; inc beyond MAX_VAL is silently absorbed.
//
// Ports: clk, reset (async, active-high), inc, clr -> count[WIDTH-1:0]
module sat_counter #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != MAX_VAL)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Purpose : serial pattern detector with run-time pattern/length/overlap and a saturating match count.
// Latency : out and match_count reflect a tick one clock after it is sampled; out holds until the next tick.
// Backpress: none; every tick without load is consumed, a tick coinciding with load is dropped.
//
// Ports: clk, reset (async, active-high)
//        bus (seq_detector_param_if.slave): in/tick serial input, load + cfg_* configuration,
//        clr_count, and outputs out, progress (history fill level), match_count.
module seq_detector_param #(
   parameter int          MAX_LEN     = 8,
   parameter int          CNT_W       = 8,
   parameter logic [31:0] DEF_PATTERN = seq_det_pkg::DEF_PATTERN,
   parameter int          DEF_LEN     = seq_det_pkg::DEF_LEN,
   parameter bit          DEF_OVERLAP = seq_det_pkg::DEF_OVERLAP
) (
   input logic                 clk,
   input logic                 reset,
   seq_detector_param_if.slave bus
);
   import seq_det_pkg::*;

   localparam int            LW       = lw_of(MAX_LEN);
   localparam logic [LW-1:0] FILL_MAX = LW'(MAX_LEN);

   // Registered configuration; detection never looks at cfg_* directly.
   logic [MAX_LEN-1:0] r_pattern;
   logic [LW-1:0]      r_len;
   logic               r_overlap;

   // The oldest history bit would be shifted out on the very tick it could be
   // compared, so only MAX_LEN-1 bits need storing; the incoming bit completes
   // the MAX_LEN-wide window used for comparison.
   logic [MAX_LEN-2:0] r_hist;
   logic               r_out;

   logic               w_accept;
   logic [MAX_LEN-1:0] w_hist_next;
   logic [MAX_LEN-1:0] w_mask;
   logic [LW-1:0]      w_fill;
   logic [LW-1:0]      w_fill_next;
   logic               w_len_ok;
   logic               w_match;
   logic               w_fill_clr;
   logic [CNT_W-1:0]   w_count;

   // A tick that arrives together with load is swallowed by the reconfiguration.
   assign w_accept    = bus.tick & ~bus.load;
   assign w_hist_next = {r_hist, bus.in};

   // Fill value as it will be after this tick (before any non-overlap clear).
   assign w_fill_next = (w_fill == FILL_MAX) ? w_fill : w_fill + 1'b1;

   // Length 0 would give an empty mask that matches everything, and lengths
   // beyond MAX_LEN cannot be satisfied, so both switch detection off.
   assign w_len_ok = (r_len != '0) && (r_len <= FILL_MAX);

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         w_mask[i] = (i < int'(r_len));
      end
   end

   // Requiring the fill to cover len keeps stale/zero history from forming a
   // match, and in non-overlap mode forces len fresh bits after each hit.
   assign w_match = w_len_ok
                 && (((w_hist_next ^ r_pattern) & w_mask) == '0)
                 && (w_fill_next >= r_len);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hist    <= '0;
         r_out     <= 1'b0;
         r_pattern <= DEF_PATTERN[MAX_LEN-1:0];
         r_len     <= LW'(DEF_LEN);
         r_overlap <= DEF_OVERLAP;
      end else if (bus.load) begin
         r_hist    <= '0;
         r_out     <= 1'b0;
         r_pattern <= bus.cfg_pattern;
         r_len     <= bus.cfg_len;
         r_overlap <= bus.cfg_overlap;
      end else if (w_accept) begin
         r_hist    <= w_hist_next[MAX_LEN-2:0];
         r_out     <= w_match;
      end
   end

   // Fill restarts on reconfiguration, and after a hit when overlaps are not allowed.
   assign w_fill_clr = bus.load | (w_accept & w_match & ~r_overlap);

   sat_counter #(
      .WIDTH   (LW),
      .MAX_VAL (FILL_MAX)
   ) u_fill (
      .clk   (clk),
      .reset (reset),
      .inc   (w_accept),
      .clr   (w_fill_clr),
      .count (w_fill)
   );

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_accept & w_match),
      .clr   (bus.clr_count),
      .count (w_count)
   );

   assign bus.out         = r_out;
   assign bus.progress    = w_fill;
   assign bus.match_count = w_count;

endmodule

// File: tb/tb_seq_detector_param.sv
// Purpose : self-checking bench for seq_detector_param (default counter and a 2-bit counter instance).
// Latency : expectations are queued per tick and checked the half cycle after the sampling edge.
// Backpress: n/a.
module tb_seq_detector_param;

   typedef struct {
      logic o;
      int   p;
      int   c;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea;
   exp_t eb;

   seq_detector_param_if #(.MAX_LEN(8), .CNT_W(8)) ifa ();
   seq_detector_param_if #(.MAX_LEN(8), .CNT_W(2)) ifb ();

   seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   task automatic cmp(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick_a(input logic b, input logic eo, input int ep, input int ec);
      exp_t e;
      @(negedge clk);
      ifa.in   = b;
      ifa.tick = 1'b1;
      e.o = eo; e.p = ep; e.c = ec;
      qa.push_back(e);
      @(negedge clk);
      ifa.tick = 1'b0;
   endtask

   task automatic tick_b(input logic b, input logic clr, input logic eo, input int ep, input int ec);
      exp_t e;
      @(negedge clk);
      ifb.in        = b;
      ifb.tick      = 1'b1;
      ifb.clr_count = clr;
      e.o = eo; e.p = ep; e.c = ec;
      qb.push_back(e);
      @(negedge clk);
      ifb.tick      = 1'b0;
      ifb.clr_count = 1'b0;
   endtask

   task automatic load_a(input logic [7:0] pat, input int len, input logic ov, input logic tk);
      @(negedge clk);
      ifa.load        = 1'b1;
      ifa.cfg_pattern = pat;
      ifa.cfg_len     = 4'(len);
      ifa.cfg_overlap = ov;
      ifa.tick        = tk;
      ifa.in          = 1'b1;
      @(negedge clk);
      ifa.load = 1'b0;
      ifa.tick = 1'b0;
   endtask

   // Monitors: whenever a tick is accepted, the next half cycle presents a result.
   always @(posedge clk) begin
      if (ifa.tick && !ifa.load) begin
         @(negedge clk);
         if (qa.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL mon_a: output with no expectation queued, out=%0d", ifa.out);
         end else begin
            ea = qa.pop_front();
            cmp("a_out",      int'(ifa.out),         int'(ea.o));
            cmp("a_progress", int'(ifa.progress),    ea.p);
            cmp("a_count",    int'(ifa.match_count), ea.c);
         end
      end
   end

   always @(posedge clk) begin
      if (ifb.tick && !ifb.load) begin
         @(negedge clk);
         if (qb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL mon_b: output with no expectation queued, out=%0d", ifb.out);
         end else begin
            eb = qb.pop_front();
            cmp("b_out",      int'(ifb.out),         int'(eb.o));
            cmp("b_progress", int'(ifb.progress),    eb.p);
            cmp("b_count",    int'(ifb.match_count), eb.c);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] b_bits;
      logic [7:0]  a5_bits;
      int          t;

      ifa.in = 0; ifa.tick = 0; ifa.load = 0; ifa.cfg_pattern = '0;
      ifa.cfg_len = '0; ifa.cfg_overlap = 0; ifa.clr_count = 0;
      ifb.in = 0; ifb.tick = 0; ifb.load = 0; ifb.cfg_pattern = '0;
      ifb.cfg_len = '0; ifb.cfg_overlap = 0; ifb.clr_count = 0;

      // Reset state
      #1;
      cmp("rst_a_out",      int'(ifa.out),         0);
      cmp("rst_a_progress", int'(ifa.progress),    0);
      cmp("rst_a_count",    int'(ifa.match_count), 0);
      cmp("rst_b_count",    int'(ifb.match_count), 0);
      @(negedge clk);
      reset = 1'b0;

      // 2-bit counter, default 1011 overlapping: hits at ticks 4,7,10,13,16; count sticks at 3.
      b_bits = 16'b1011011011011011;
      for (int i = 0; i < 16; i++) begin
         t = i + 1;
         tick_b(b_bits[15-i], 1'b0,
                ((t % 3) == 1) && (t >= 4),
                (t > 8) ? 8 : t,
                (t < 4) ? 0 : (t < 7) ? 1 : (t < 10) ? 2 : 3);
      end
      tick_b(1'b0, 1'b0, 1'b0, 8, 3);
      tick_b(1'b1, 1'b0, 1'b0, 8, 3);
      // clear together with a matching tick: clear wins, out still flags the hit
      tick_b(1'b1, 1'b1, 1'b1, 8, 0);

      // Defaults: 1,0,1,1,0,1,1 -> hits at ticks 4 and 7
      tick_a(1, 0, 1, 0);
      tick_a(0, 0, 2, 0);
      tick_a(1, 0, 3, 0);
      tick_a(1, 1, 4, 1);
      tick_a(0, 0, 5, 1);
      tick_a(1, 0, 6, 1);
      tick_a(1, 1, 7, 2);
      repeat (3) @(negedge clk);
      cmp("a_out_hold_idle", int'(ifa.out), 1);

      // Pattern 11, len 2, no overlap; the tick coinciding with load is dropped
      load_a(8'b11, 2, 1'b0, 1'b1);
      cmp("load_progress", int'(ifa.progress), 0);
      cmp("load_out",      int'(ifa.out),      0);
      tick_a(1, 0, 1, 2);
      tick_a(1, 1, 0, 3);
      tick_a(1, 0, 1, 3);
      tick_a(1, 1, 0, 4);

      // Same pattern with overlap
      load_a(8'b11, 2, 1'b1, 1'b0);
      tick_a(1, 0, 1, 4);
      tick_a(1, 1, 2, 5);
      tick_a(1, 1, 3, 6);
      tick_a(1, 1, 4, 7);

      @(negedge clk);
      ifa.clr_count = 1'b1;
      @(negedge clk);
      ifa.clr_count = 1'b0;
      cmp("clr_count", int'(ifa.match_count), 0);

      // Full-width pattern A5 with gaps between ticks
      load_a(8'hA5, 8, 1'b1, 1'b0);
      a5_bits = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         tick_a(a5_bits[7-i], (i == 7), i + 1, (i == 7) ? 1 : 0);
         repeat (2) @(negedge clk);
      end
      cmp("a5_out_hold_gap", int'(ifa.out), 1);
      tick_a(0, 0, 8, 1);

      // Reset mid-sequence
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tick_a(1, 0, 1, 0);
      tick_a(0, 0, 2, 0);
      tick_a(1, 0, 3, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      cmp("midrst_progress", int'(ifa.progress),    0);
      cmp("midrst_count",    int'(ifa.match_count), 0);
      @(negedge clk);
      reset = 1'b0;
      tick_a(1, 0, 1, 0);
      tick_a(0, 0, 2, 0);
      tick_a(1, 0, 3, 0);
      tick_a(1, 1, 4, 1);

      // len 0 disables detection, even with an all-zero pattern and history
      load_a(8'h00, 0, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) tick_a(0, 0, i, 1);

      // len beyond MAX_LEN also disables detection; fill saturates at 8
      load_a(8'h00, 9, 1'b1, 1'b0);
      for (int i = 1; i <= 10; i++) tick_a(0, 0, (i > 8) ? 8 : i, 1);

      for (int k = 0; k < 50 && (qa.size() != 0 || qb.size() != 0); k++) @(negedge clk);
      if (qa.size() != 0 || qb.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL drain: %0d/%0d expectations left, expected 0", qa.size(), qb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits, legal 2..32.
REQ-002 Parameter CNT_W, default 8: width of match counter.
REQ-003 Parameter DEF_PATTERN, default 'b1011: pattern loaded at reset.
REQ-004 Parameter DEF_LEN, default 4: pattern length loaded at reset.
REQ-005 Parameter DEF_OVERLAP, default 1: overlap mode loaded at reset.
REQ-006 Port clk  input  1  sole clock, rising edge.
REQ-007 Port reset  input  1  asynchronous, active-high reset.
REQ-008 Port in  input  1  serial data bit, sampled only on tick.
REQ-009 Port tick  input  1  single-cycle sample strobe.
REQ-010 Port load  input  1  latch cfg_pattern/cfg_len/cfg_overlap.
REQ-011 Port cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 arrives first, bit 0 arrives last.
REQ-012 Port cfg_len  input  LW=$clog2(MAX_LEN+1)  pattern length.
REQ-013 Port cfg_overlap  input  1  1 = overlapping matches allowed.
REQ-014 Port clr_count  input  1  synchronous clear of match_count.
REQ-015 Port out  output  1  registered match flag.
REQ-016 Port progress  output  LW  number of valid history bits (fill level).
REQ-017 Port match_count  output  CNT_W  saturating count of matches.

Function
REQ-018 Config registers (pattern, len, overlap) SHALL update only on clk edge with load=1; detection SHALL always use the registered copy.
REQ-019 load SHALL clear the history and fill, and deassert out; load with tick in the same cycle SHALL ignore that tick.
REQ-020 On tick (no load), history SHALL shift: hist <= {hist[MAX_LEN-2:0], in}; fill SHALL increment, saturating at MAX_LEN.
REQ-021 Without tick, history, fill and out SHALL hold.
REQ-022 Match condition on a tick: the new hist[len-1:0] equals pattern[len-1:0], and the new fill >= len.
REQ-023 On a matching tick, out SHALL be 1 from the next cycle until the next accepted tick; otherwise out SHALL be 0 after each tick.
REQ-024 Overlap=1: fill SHALL be unaffected by a match; overlap=0: fill SHALL reset to 0 on a matching tick, so the next match needs len fresh bits.
REQ-025 Registered len of 0 or > MAX_LEN SHALL disable detection; out stays 0, while shifting and fill continue.
REQ-026 match_count SHALL increment by 1 per match, saturating at 2^CNT_W-1 with no wrap.
REQ-027 clr_count SHALL zero match_count; it takes priority over a simultaneous increment.
REQ-028 With default parameters and no load, the behaviour SHALL equal an overlapping detector for 1011, with out asserted for one tick interval after each final 1.

Reset
REQ-029 While reset=1: hist=0, fill=0, out=0, match_count=0, pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP, all immediately (asynchronously).
REQ-030 Reset asserted mid-sequence SHALL discard partial progress; the first tick after release is history bit 1.

Structure
REQ-031 Package seq_det_pkg SHALL hold the DEF_* defaults and a function computing LW from MAX_LEN.
REQ-032 Sub-module sat_counter (parameter width, inputs inc/clr, saturating) SHALL implement match_count; fill may reuse it.

Verification
REQ-033 Defaults, ticks on in = 1,0,1,1,0,1,1 -> out high after ticks 4 and 7, match_count=2.
REQ-034 load pattern 'b11, len 2, overlap=0; ticks on in = 1,1,1,1 -> matches at ticks 2 and 4 only, count=2; repeat with overlap=1 -> matches at ticks 2,3,4, count=3.
REQ-035 MAX_LEN=8, load pattern 'hA5, len 8; feed 1,0,1,0,0,1,0,1 with a 3-cycle gap between ticks -> a single out pulse lasting until the next tick; progress=8.
REQ-036 CNT_W=2, default pattern, 5 matches -> match_count stays 3; clr_count together with a matching tick -> count=0.
REQ-037 Reset pulse after in = 1,0,1 -> progress=0 immediately; then a single 1 gives no match; load len=0 -> out never asserts.
